// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first.
// The serial input passes through a two-flop synchroniser; a falling edge on the
// synchronised line starts a frame, each bit is sampled at mid-period, and the
// frame ends with a one-cycle o_valid (stop bit high) or o_err (stop bit low).
// o_state exposes the FSM state (IDLE=0, START=1, DATA=2, STOP=3) for observation.
module uart_rx #(
    parameter int D    = 234,   // clock cycles per bit, 4..255
    parameter int HALF = D / 2  // cycles from start-edge detection to start mid-sample
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_err,
    output logic       o_busy,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [7:0] BIT_LAST  = 8'(D - 1);
    localparam logic [7:0] HALF_LAST = 8'(HALF - 1);

    state_t      state_q, state_d;
    logic        s1_q, s2_q, p_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic        fall;
    logic        half_hit;
    logic        bit_hit;

    assign fall     = p_q & ~s2_q;
    assign half_hit = (cnt_q == HALF_LAST);
    assign bit_hit  = (cnt_q == BIT_LAST);

    // State register plus synchroniser, counters, shift register and output flops.
    // Synchroniser and previous-sample flops reset high so an idle line is not a start edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            p_q     <= 1'b1;
            cnt_q   <= 8'd0;
            bit_q   <= 4'd0;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= i_rx;
            s2_q    <= s1_q;
            p_q     <= s2_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: start edge, mid-start check, eight data bits, mid-stop exit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fall) state_d = START;
            end
            START: begin
                if (half_hit) state_d = s2_q ? IDLE : DATA;
            end
            DATA: begin
                if (bit_hit && (bit_q == 4'd7)) state_d = STOP;
            end
            STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
                if (bit_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: counters, bit shifting and the registered strobes.
    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                bit_d = 4'd0;
            end
            START: begin
                if (half_hit) begin
                    cnt_d = 8'd0;
                    bit_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (bit_hit) begin
                    shreg_d = {s2_q, shreg_q[7:1]};
                    cnt_d   = 8'd0;
                    bit_d   = (bit_q == 4'd7) ? 4'd0 : bit_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STOP: begin
                if (bit_hit) begin
                    cnt_d = 8'd0;
                    if (s2_q) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                cnt_d = 8'd0;
                bit_d = 4'd0;
            end
        endcase
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_busy  = (state_q != IDLE);
    assign o_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a frame-level reference model.
// Instance a uses 16 cycles/bit for most scenarios; instance b uses 234 for baud skew.
module tb_uart_rx;

  localparam int DA = 16;
  localparam int DB = 234;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic       rx_a  = 1'b1, rx_b  = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, err_a, err_b, busy_a, busy_b;
  logic [1:0] state_a, state_b;

  uart_rx #(.D(DA)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_rx(rx_a),
    .o_data(data_a), .o_valid(valid_a), .o_err(err_a), .o_busy(busy_a), .o_state(state_a)
  );

  uart_rx #(.D(DB)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_rx(rx_b),
    .o_data(data_b), .o_valid(valid_b), .o_err(err_b), .o_busy(busy_b), .o_state(state_b)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- output monitors ----------------
  logic [7:0] got_a[$];
  int         vcyc_a[$];
  logic [7:0] err_data_a[$];
  int         busy_cnt_a = 0;
  int         busy_rise_a = -1;
  int         viol_a = 0;
  bit         prev_strobe_a = 1'b0;
  bit         prev_busy_a = 1'b0;

  logic [7:0] got_b[$];
  int         err_cnt_b = 0;

  always @(negedge clk) begin
    if (valid_a) begin
      got_a.push_back(data_a);
      vcyc_a.push_back(cyc);
    end
    if (err_a) err_data_a.push_back(data_a);
    if (busy_a) busy_cnt_a++;
    if (busy_a && !prev_busy_a) busy_rise_a = cyc;
    if ((valid_a && err_a) || ((valid_a || err_a) && prev_strobe_a) || ((valid_a || err_a) && busy_a))
      viol_a++;
    prev_strobe_a = valid_a || err_a;
    prev_busy_a   = busy_a;
    if (valid_b) got_b.push_back(data_b);
    if (err_b) err_cnt_b++;
  end

  task automatic clear_mon_a();
    got_a.delete();
    vcyc_a.delete();
    err_data_a.delete();
    busy_cnt_a  = 0;
    busy_rise_a = -1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx_a = v;
    else rx_b = v;
  endtask

  // Called at a negedge. start_cyc is the posedge at which the first synchroniser flop sees the start bit.
  task automatic send_frame(input int which, input logic [7:0] b, input logic stop_bit,
                            input int bitlen, output int start_cyc);
    start_cyc = cyc + 1;
    set_rx(which, 1'b0);
    repeat (bitlen) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(which, b[i]);
      repeat (bitlen) @(negedge clk);
    end
    set_rx(which, stop_bit);
    repeat (bitlen) @(negedge clk);
  endtask

  task automatic idle_a(input int n);
    rx_a = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Reference model: the bytes expected on o_data, in order, from what the sender put on the line.
  logic [7:0] exp_q[$];
  logic [7:0] last_good_a = 8'h00;

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (data_a !== 8'h00) begin bad++; $display("FAIL reset_data_a got=%h exp=00", data_a); end
    total++; if ({valid_a, err_a, busy_a} !== 3'b000) begin bad++; $display("FAIL reset_flags_a got=%b exp=000", {valid_a, err_a, busy_a}); end
    total++; if (state_a !== 2'd0) begin bad++; $display("FAIL reset_state_a got=%0d exp=0", state_a); end
    total++; if ({data_b, valid_b, err_b, busy_b} !== 11'd0) begin bad++; $display("FAIL reset_b got=%h exp=0", {data_b, valid_b, err_b, busy_b}); end
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%b exp=0", busy_a); end
  endtask

  task automatic test_single_byte();
    int t0;
    clear_mon_a();
    send_frame(0, 8'h55, 1'b1, DA, t0);
    idle_a(2 * DA);
    last_good_a = 8'h55;
    total++; if (got_a.size() != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", got_a.size()); end
    else begin
      total++; if (got_a[0] !== 8'h55) begin bad++; $display("FAIL single_data got=%h exp=55", got_a[0]); end
      total++; if (vcyc_a[0] != t0 + 2 + DA / 2 + 9 * DA) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", vcyc_a[0] - t0, 2 + DA / 2 + 9 * DA); end
    end
    total++; if (busy_rise_a != t0 + 2) begin bad++; $display("FAIL busy_rise got=%0d exp=%0d", busy_rise_a - t0, 2); end
    total++; if (err_data_a.size() != 0) begin bad++; $display("FAIL single_err got=%0d exp=0", err_data_a.size()); end
    total++; if (data_a !== 8'h55) begin bad++; $display("FAIL single_hold got=%h exp=55", data_a); end
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [7:0] bytes[3];
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'hA5;
    clear_mon_a();
    for (int i = 0; i < 3; i++) send_frame(0, bytes[i], 1'b1, DA, t0);
    idle_a(2 * DA);
    last_good_a = 8'hA5;
    total++; if (got_a.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", got_a.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++; if (got_a[i] !== bytes[i]) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got_a[i], bytes[i]); end
    end
    total++; if (err_data_a.size() != 0) begin bad++; $display("FAIL b2b_err got=%0d exp=0", err_data_a.size()); end
  endtask

  task automatic test_glitch();
    clear_mon_a();
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    idle_a(3 * DA);
    total++; if (busy_cnt_a == 0) begin bad++; $display("FAIL glitch_busy got=0 exp=nonzero"); end
    total++; if (got_a.size() + err_data_a.size() != 0) begin bad++; $display("FAIL glitch_strobe got=%0d exp=0", got_a.size() + err_data_a.size()); end
    total++; if (state_a !== 2'd0) begin bad++; $display("FAIL glitch_state got=%0d exp=0", state_a); end
    total++; if (data_a !== last_good_a) begin bad++; $display("FAIL glitch_data got=%h exp=%h", data_a, last_good_a); end
  endtask

  task automatic test_framing_error();
    int t0;
    clear_mon_a();
    send_frame(0, 8'h3C, 1'b0, DA, t0);
    total++; if (err_data_a.size() != 1) begin bad++; $display("FAIL frame_err_count got=%0d exp=1", err_data_a.size()); end
    else begin
      total++; if (err_data_a[0] !== last_good_a) begin bad++; $display("FAIL frame_err_data got=%h exp=%h", err_data_a[0], last_good_a); end
    end
    total++; if (got_a.size() != 0) begin bad++; $display("FAIL frame_err_valid got=%0d exp=0", got_a.size()); end
    // break: line stays low, receiver must not re-arm
    busy_cnt_a = 0;
    repeat (40) @(negedge clk);
    total++; if (busy_cnt_a != 0) begin bad++; $display("FAIL break_rearm got=%0d exp=0", busy_cnt_a); end
    idle_a(DA);
    send_frame(0, 8'h81, 1'b1, DA, t0);
    idle_a(2 * DA);
    last_good_a = 8'h81;
    total++; if (got_a.size() != 1 || got_a[0] !== 8'h81) begin bad++; $display("FAIL after_break got=%h n=%0d exp=81", data_a, got_a.size()); end
    total++; if (err_data_a.size() != 1) begin bad++; $display("FAIL after_break_err got=%0d exp=1", err_data_a.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    logic [7:0] b;
    b = 8'h12;
    clear_mon_a();
    rx_a = 1'b0;
    repeat (DA) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_a = b[i];
      repeat (DA) @(negedge clk);
    end
    rx_a = b[4];
    repeat (DA / 2) @(negedge clk);
    total++; if (state_a !== 2'd2) begin bad++; $display("FAIL mid_frame_state got=%0d exp=2", state_a); end
    rx_a  = 1'b1;
    rst_a = 1'b1;
    @(negedge clk);
    total++; if ({data_a, valid_a, err_a, busy_a, state_a} !== 13'd0) begin bad++; $display("FAIL mid_reset_outputs got=%h exp=0", {data_a, valid_a, err_a, busy_a, state_a}); end
    rst_a = 1'b0;
    idle_a(12 * DA);
    last_good_a = 8'h00;
    total++; if (got_a.size() + err_data_a.size() != 0) begin bad++; $display("FAIL mid_reset_strobe got=%0d exp=0", got_a.size() + err_data_a.size()); end
    send_frame(0, 8'h34, 1'b1, DA, t0);
    idle_a(2 * DA);
    last_good_a = 8'h34;
    total++; if (got_a.size() != 1 || data_a !== 8'h34) begin bad++; $display("FAIL post_reset_byte got=%h n=%0d exp=34", data_a, got_a.size()); end
  endtask

  task automatic test_random();
    int t0;
    int n_err_exp;
    logic [7:0] b;
    logic stop_bit;
    logic prev_stop;
    int gap;
    clear_mon_a();
    exp_q.delete();
    n_err_exp = 0;
    prev_stop = 1'b1;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 4) != 0);
      gap = prev_stop ? $urandom_range(0, 2) * DA + $urandom_range(0, 3)
                      : $urandom_range(1, 2) * DA;
      if (gap > 0) idle_a(gap);
      send_frame(0, b, stop_bit, DA, t0);
      if (stop_bit) exp_q.push_back(b);
      else n_err_exp++;
      prev_stop = stop_bit;
    end
    idle_a(2 * DA);
    total++; if (got_a.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (got_a[i] !== exp_q[i]) begin bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, got_a[i], exp_q[i]); end
    end
    total++; if (err_data_a.size() != n_err_exp) begin bad++; $display("FAIL rand_err got=%0d exp=%0d", err_data_a.size(), n_err_exp); end
    if (exp_q.size() > 0) last_good_a = exp_q[exp_q.size() - 1];
    total++; if (data_a !== last_good_a) begin bad++; $display("FAIL rand_hold got=%h exp=%h", data_a, last_good_a); end
  endtask

  task automatic test_baud_skew();
    int t0;
    got_b.delete();
    rx_b = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(1, 8'hC3, 1'b1, 225, t0);
    rx_b = 1'b1;
    repeat (2 * DB) @(negedge clk);
    send_frame(1, 8'hC3, 1'b1, 243, t0);
    rx_b = 1'b1;
    repeat (2 * DB) @(negedge clk);
    total++; if (got_b.size() != 2) begin bad++; $display("FAIL skew_count got=%0d exp=2", got_b.size()); end
    else for (int i = 0; i < 2; i++) begin
      total++; if (got_b[i] !== 8'hC3) begin bad++; $display("FAIL skew_data[%0d] got=%h exp=c3", i, got_b[i]); end
    end
    total++; if (err_cnt_b != 0) begin bad++; $display("FAIL skew_err got=%0d exp=0", err_cnt_b); end
  endtask

  task automatic test_loopback();
    int t0;
    int nbad;
    clear_mon_a();
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      send_frame(0, 8'(i), 1'b1, DA, t0);
      exp_q.push_back(8'(i));
    end
    idle_a(2 * DA);
    total++; if (got_a.size() != 256) begin bad++; $display("FAIL loop_count got=%0d exp=256", got_a.size()); end
    else begin
      nbad = 0;
      for (int i = 0; i < 256; i++) if (got_a[i] !== exp_q[i]) begin
        nbad++;
        if (nbad <= 4) $display("FAIL loop_data[%0d] got=%h exp=%h", i, got_a[i], exp_q[i]);
      end
      total++; if (nbad != 0) bad++;
    end
    total++; if (err_data_a.size() != 0) begin bad++; $display("FAIL loop_err got=%0d exp=0", err_data_a.size()); end
    total++; if (viol_a != 0) begin bad++; $display("FAIL strobe_rules got=%0d exp=0", viol_a); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_random();
    test_baud_skew();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
